// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline: tracks in-flight destination writes past ID,
// raises a same-cycle load-use stall and registers forwarding selects for the EX stage.
module pipe_hazard_scoreboard #(
    parameter int STAGES      = 4,
    parameter int REG_BITS    = 5,
    parameter int LOAD_READY  = 1,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      IssueValid,
    input  logic [REG_BITS-1:0]       IssueRs,
    input  logic [REG_BITS-1:0]       IssueRt,
    input  logic                      IssueUsesRs,
    input  logic                      IssueUsesRt,
    input  logic [REG_BITS-1:0]       IssueDest,
    input  logic                      IssueWrites,
    input  logic                      IssueIsLoad,
    input  logic                      Flush,
    output logic                      Stall,
    output logic [$clog2(STAGES)-1:0] FwdSelRs,
    output logic [$clog2(STAGES)-1:0] FwdSelRt,
    output logic [31:0]               StallCount,
    output logic [31:0]               FlushCount
);

    localparam int SEL_W = $clog2(STAGES);

    logic [STAGES-1:0]               valid_q, valid_d;
    logic [STAGES-1:0]               writes_q, writes_d;
    logic [STAGES-1:0]               load_q, load_d;
    logic [STAGES-1:0][REG_BITS-1:0] dest_q, dest_d;
    logic [SEL_W-1:0]                fwd_rs_q, fwd_rs_d;
    logic [SEL_W-1:0]                fwd_rt_q, fwd_rt_d;
    logic [31:0]                     stall_cnt_q, stall_cnt_d;
    logic [31:0]                     flush_cnt_q, flush_cnt_d;

    logic             rs_hit, rt_hit;
    logic [SEL_W-1:0] rs_idx, rt_idx;
    logic             rs_load_haz, rt_load_haz;
    logic             stall_c, issue_c;

    // Scan oldest to youngest so the youngest matching entry is the one left standing.
    always_comb begin
        rs_hit = 1'b0;
        rs_idx = '0;
        rt_hit = 1'b0;
        rt_idx = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (IssueUsesRs && (IssueRs != '0) && valid_q[k] && writes_q[k] && (dest_q[k] == IssueRs)) begin
                rs_hit = 1'b1;
                rs_idx = SEL_W'(k);
            end
            if (IssueUsesRt && (IssueRt != '0) && valid_q[k] && writes_q[k] && (dest_q[k] == IssueRt)) begin
                rt_hit = 1'b1;
                rt_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        rs_load_haz = rs_hit && load_q[rs_idx] && (int'(rs_idx) < LOAD_READY);
        rt_load_haz = rt_hit && load_q[rt_idx] && (int'(rt_idx) < LOAD_READY);
        stall_c     = IssueValid && !Flush && (rs_load_haz || rt_load_haz);
        issue_c     = IssueValid && !stall_c && !Flush;
    end

    always_comb begin
        fwd_rs_d = '0;
        fwd_rt_d = '0;
        if (issue_c && rs_hit && (int'(rs_idx) + 1 < STAGES)) fwd_rs_d = SEL_W'(int'(rs_idx) + 1);
        if (issue_c && rt_hit && (int'(rt_idx) + 1 < STAGES)) fwd_rt_d = SEL_W'(int'(rt_idx) + 1);
    end

    // Flush kills the youngest pre-shift entries as they move down one slot.
    always_comb begin
        valid_d[0]  = issue_c;
        writes_d[0] = IssueWrites;
        load_d[0]   = IssueIsLoad;
        dest_d[0]   = IssueDest;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k]  = valid_q[k-1] && !(Flush && (k - 1 < FLUSH_DEPTH));
            writes_d[k] = writes_q[k-1];
            load_d[k]   = load_q[k-1];
            dest_d[k]   = dest_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (Flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q     <= '0;
            writes_q    <= '0;
            load_q      <= '0;
            dest_q      <= '0;
            fwd_rs_q    <= '0;
            fwd_rt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            writes_q    <= writes_d;
            load_q      <= load_d;
            dest_q      <= dest_d;
            fwd_rs_q    <= fwd_rs_d;
            fwd_rt_q    <= fwd_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall      = stall_c;
    assign FwdSelRs   = fwd_rs_q;
    assign FwdSelRt   = fwd_rt_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule
